// File: rtl/j68_useq.sv
`default_nettype none
//============================================================================
// Module   : j68_useq
// Purpose  : Microcode sequencer for the J68 core. Computes the next
//            microcode ROM address from the current micro-instruction, the
//            branch decision, the decode ROM entry point and the exception
//            request. Provides a circular return stack and a loop counter.
// Ports    : clk, rst_n     - clock, asynchronous active-low reset
//            ena           - clock enable, low freezes all state
//            inst_in       - micro-instruction at upc
//            branch        - condition result from the test unit
//            dec_addr      - decode-ROM dispatch address
//            bus_ack       - bus cycle complete (releases WAIT)
//            exc_req       - exception request, exc_addr its handler
//            upc           - registered microcode address
//            upc_nxt       - combinational next address (sync ROM address)
//            exc_ack       - one-cycle exception-accepted pulse
//            stk_err       - sticky return-stack overflow/underflow
//            lp_cnt        - loop counter
// Revision : 1.0 - initial release
//============================================================================
module j68_useq #(
    parameter int               UPC_W     = 11,
    parameter int               STK_DEPTH = 8,
    parameter logic [UPC_W-1:0] RST_ADDR  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [19:0]      inst_in,
    input  logic             branch,
    input  logic [UPC_W-1:0] dec_addr,
    input  logic             bus_ack,
    input  logic             exc_req,
    input  logic [UPC_W-1:0] exc_addr,
    output logic [UPC_W-1:0] upc,
    output logic [UPC_W-1:0] upc_nxt,
    output logic             exc_ack,
    output logic             stk_err,
    output logic [5:0]       lp_cnt
);

    localparam int               SP_W   = $clog2(STK_DEPTH);
    localparam int               CNT_W  = SP_W + 1;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(STK_DEPTH);

    localparam logic [2:0] OP_NEXT = 3'd0;
    localparam logic [2:0] OP_JMP  = 3'd1;
    localparam logic [2:0] OP_CALL = 3'd2;
    localparam logic [2:0] OP_RET  = 3'd3;
    localparam logic [2:0] OP_DISP = 3'd4;
    localparam logic [2:0] OP_LOOP = 3'd5;
    localparam logic [2:0] OP_WAIT = 3'd6;

    logic [UPC_W-1:0] upc_q, upc_d;
    logic [SP_W-1:0]  top_q, top_d;     // slot the next push writes
    logic [CNT_W-1:0] cnt_q, cnt_d;     // number of valid entries
    logic [5:0]       lp_cnt_q, lp_cnt_d;
    logic             exc_ack_q, exc_ack_d;
    logic             stk_err_q, stk_err_d;
    logic [UPC_W-1:0] stk_q [STK_DEPTH];

    logic [2:0]       op;
    logic             ld;
    logic [UPC_W-1:0] tgt;
    logic [UPC_W-1:0] upc_inc;
    logic [SP_W-1:0]  top_m1;
    logic             exc_take;
    logic             push;
    logic             unused_tst;

    assign op      = inst_in[19:17];
    assign ld      = inst_in[16];
    assign tgt     = inst_in[UPC_W-1:0];
    assign upc_inc = upc_q + 1'b1;
    assign top_m1  = top_q - 1'b1;

    // Condition-select bits belong to the test unit; only branch is used here.
    assign unused_tst = ^inst_in[15:11];

    // A WAIT in progress can only be interrupted on its bus_ack cycle.
    assign exc_take = exc_req & ~((op == OP_WAIT) & ~bus_ack);

    always_comb begin
        upc_d     = upc_q;
        top_d     = top_q;
        cnt_d     = cnt_q;
        lp_cnt_d  = lp_cnt_q;
        exc_ack_d = exc_ack_q;
        stk_err_d = stk_err_q;
        push      = 1'b0;
        if (ena) begin
            exc_ack_d = 1'b0;
            if (exc_take) begin
                upc_d     = exc_addr;
                cnt_d     = '0;
                lp_cnt_d  = '0;
                exc_ack_d = 1'b1;
            end else begin
                case (op)
                    OP_NEXT: begin
                        upc_d = upc_inc;
                        if (ld) begin
                            lp_cnt_d = inst_in[5:0];
                        end
                    end
                    OP_JMP: begin
                        upc_d = branch ? tgt : upc_inc;
                    end
                    OP_CALL: begin
                        if (branch) begin
                            push  = 1'b1;
                            upc_d = tgt;
                            top_d = top_q + 1'b1;
                            // Full stack: the write lands on the oldest slot.
                            if (cnt_q == C_FULL) begin
                                stk_err_d = 1'b1;
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end else begin
                            upc_d = upc_inc;
                        end
                    end
                    OP_RET: begin
                        if (cnt_q == '0) begin
                            upc_d     = RST_ADDR;
                            stk_err_d = 1'b1;
                        end else begin
                            upc_d = stk_q[top_m1];
                            top_d = top_m1;
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                    OP_DISP: begin
                        upc_d = dec_addr;
                    end
                    OP_LOOP: begin
                        if (lp_cnt_q != 6'd0) begin
                            lp_cnt_d = lp_cnt_q - 6'd1;
                            upc_d    = tgt;
                        end else begin
                            upc_d = upc_inc;
                        end
                    end
                    OP_WAIT: begin
                        if (bus_ack) begin
                            upc_d = upc_inc;
                        end
                    end
                    default: begin  // TRAP
                        upc_d     = exc_addr;
                        exc_ack_d = 1'b1;
                    end
                endcase
            end
        end
    end

    // The ROM read address follows reset immediately.
    assign upc_nxt = rst_n ? upc_d : RST_ADDR;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upc_q     <= RST_ADDR;
            top_q     <= '0;
            cnt_q     <= '0;
            lp_cnt_q  <= '0;
            exc_ack_q <= 1'b0;
            stk_err_q <= 1'b0;
        end else begin
            upc_q     <= upc_d;
            top_q     <= top_d;
            cnt_q     <= cnt_d;
            lp_cnt_q  <= lp_cnt_d;
            exc_ack_q <= exc_ack_d;
            stk_err_q <= stk_err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STK_DEPTH; i++) begin
                stk_q[i] <= '0;
            end
        end else if (push) begin
            stk_q[top_q] <= upc_inc;
        end
    end

    assign upc     = upc_q;
    assign exc_ack = exc_ack_q;
    assign stk_err = stk_err_q;
    assign lp_cnt  = lp_cnt_q;

endmodule
`default_nettype wire
